// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - pattern load / blanking / display drive bundle for seg_scan_ctrl
interface seg_scan_ctrl_if;
    logic [63:0] seg_in;
    logic        load;
    logic [7:0]  blank_mask;
    logic [7:0]  seg_data;
    logic [7:0]  seg_com;
    logic        frame_done;

    modport master (
        output seg_in,
        output load,
        output blank_mask,
        input  seg_data,
        input  seg_com,
        input  frame_done
    );

    modport slave (
        input  seg_in,
        input  load,
        input  blank_mask,
        output seg_data,
        output seg_com,
        output frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit multiplexed segment scanner with frame-synchronous double buffering
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 10000,
    parameter int DEAD_CYC = 100
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int             CW       = 16;
    localparam logic [CW-1:0]  DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW:0]    DEAD_END = (CW + 1)'(DEAD_CYC);

    logic [CW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [63:0]   shadow;
    logic [63:0]   active;
    logic [7:0]    seg_data_q;
    logic [7:0]    seg_com_q;
    logic          frame_done_q;

    logic          slot_end;
    logic          frame_end;
    logic          dead;
    logic [7:0]    digit_pat;
    logic [7:0]    com_sel;

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (idx == 3'd7);
    // Written as (cnt+1 <= DEAD_CYC) so DEAD_CYC=0 needs no special case.
    assign dead      = ({1'b0, div_cnt} + 17'd1) <= DEAD_END;
    assign digit_pat = active[{idx, 3'b000} +: 8];
    assign com_sel   = ~(8'd1 << idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            idx          <= '0;
            shadow       <= '0;
            active       <= '0;
            seg_data_q   <= 8'h00;
            seg_com_q    <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + CW'(1);
            if (slot_end) begin
                idx <= idx + 3'd1;
            end

            if (bus.load) begin
                shadow <= bus.seg_in;
            end
            // A load landing on the boundary bypasses shadow so it is shown next frame.
            if (frame_end) begin
                active <= bus.load ? bus.seg_in : shadow;
            end

            frame_done_q <= frame_end;

            if (dead || bus.blank_mask[idx]) begin
                seg_com_q  <= 8'hFF;
                seg_data_q <= 8'h00;
            end else begin
                seg_com_q  <= com_sel;
                seg_data_q <= digit_pat;
            end
        end
    end

    assign bus.seg_data   = seg_data_q;
    assign bus.seg_com    = seg_com_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed vector bench for seg_scan_ctrl (SCAN_DIV=8, DEAD_CYC=2 and 0)
module tb_seg_scan_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_ctrl_if bus();
    seg_scan_ctrl_if bus_nd();

    seg_scan_ctrl #(.SCAN_DIV(8), .DEAD_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seg_scan_ctrl #(.SCAN_DIV(8), .DEAD_CYC(0)) dut_nd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nd)
    );

    typedef struct {
        int          at;
        logic        ld;
        logic [63:0] seg;
        logic [7:0]  mask;
        logic [7:0]  com;
        logic [7:0]  data;
        logic        fd;
    } vec_t;

    vec_t tbl[$];

    int   n_chk      = 0;
    int   n_pass     = 0;
    int   edge_n     = 0;
    int   onehot_err = 0;
    int   fd_err     = 0;
    int   fd_cnt     = 0;
    int   nd_err     = 0;
    int   aa_seen    = 0;
    logic run_checks = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input int at, input logic ld, input logic [63:0] seg, input logic [7:0] mask,
                       input logic [7:0] com, input logic [7:0] data, input logic fd);
        vec_t v;
        v.at = at; v.ld = ld; v.seg = seg; v.mask = mask;
        v.com = com; v.data = data; v.fd = fd;
        tbl.push_back(v);
    endtask

    // One clock, then sample 1ns after the edge and update running invariants.
    task automatic step();
        logic [7:0] nd_exp;
        @(posedge clk);
        #1;
        edge_n++;
        if ($countones(~bus.seg_com) > 1 || $countones(~bus_nd.seg_com) > 1) onehot_err++;
        if (bus.seg_data === 8'hAA) aa_seen++;
        if (run_checks) begin
            if (bus.frame_done !== ((edge_n % 64) == 0)) fd_err++;
            if (bus.frame_done === 1'b1) fd_cnt++;
            nd_exp = ~(8'd1 << (((edge_n - 1) / 8) % 8));
            if (bus_nd.seg_com !== nd_exp) nd_err++;
        end
    endtask

    initial begin
        bus.seg_in = '0;    bus.load = 1'b0;    bus.blank_mask = 8'h00;
        bus_nd.seg_in = '0; bus_nd.load = 1'b0; bus_nd.blank_mask = 8'h00;

        //  edge ld  seg_in              mask   com    data   fd
        add(1,   0, 64'h0,              8'h00, 8'hFF, 8'h00, 0);
        add(2,   0, 64'h0,              8'h00, 8'hFF, 8'h00, 0);
        add(3,   0, 64'h0,              8'h00, 8'hFE, 8'h00, 0);
        add(8,   0, 64'h0,              8'h00, 8'hFE, 8'h00, 0);
        add(9,   0, 64'h0,              8'h00, 8'hFF, 8'h00, 0);
        add(10,  1, 64'hFC,             8'h00, 8'hFF, 8'h00, 0);
        add(11,  0, 64'h0,              8'h00, 8'hFD, 8'h00, 0);
        add(59,  0, 64'h0,              8'h00, 8'h7F, 8'h00, 0);
        add(63,  0, 64'h0,              8'h00, 8'h7F, 8'h00, 0);
        add(64,  0, 64'h0,              8'h00, 8'h7F, 8'h00, 1);
        add(65,  0, 64'h0,              8'h00, 8'hFF, 8'h00, 0);
        add(66,  0, 64'h0,              8'h00, 8'hFF, 8'h00, 0);
        add(67,  0, 64'h0,              8'h00, 8'hFE, 8'hFC, 0);
        add(72,  0, 64'h0,              8'h00, 8'hFE, 8'hFC, 0);
        add(73,  0, 64'h0,              8'h00, 8'hFF, 8'h00, 0);
        add(75,  0, 64'h0,              8'h00, 8'hFD, 8'h00, 0);
        add(128, 0, 64'h0,              8'h00, 8'h7F, 8'h00, 1);
        add(129, 0, 64'h0,              8'h00, 8'hFF, 8'h00, 0);
        add(192, 0, 64'h0,              8'h00, 8'h7F, 8'h00, 1);
        add(200, 1, {8{8'hAA}},         8'h00, 8'hFE, 8'hFC, 0);
        add(210, 1, {8{8'h55}},         8'h00, 8'hFF, 8'h00, 0);
        add(259, 0, 64'h0,              8'h00, 8'hFE, 8'h55, 0);
        add(267, 0, 64'h0,              8'h00, 8'hFD, 8'h55, 0);
        add(320, 1, {8{8'h3C}},         8'h00, 8'h7F, 8'h55, 1);
        add(323, 0, 64'h0,              8'h04, 8'hFE, 8'h3C, 0);
        add(331, 0, 64'h0,              8'h04, 8'hFD, 8'h3C, 0);
        add(337, 0, 64'h0,              8'h04, 8'hFF, 8'h00, 0);
        add(339, 0, 64'h0,              8'h04, 8'hFF, 8'h00, 0);
        add(344, 0, 64'h0,              8'h04, 8'hFF, 8'h00, 0);
        add(347, 0, 64'h0,              8'h04, 8'hF7, 8'h3C, 0);
        add(384, 0, 64'h0,              8'h04, 8'h7F, 8'h3C, 1);
        add(387, 0, 64'h0,              8'h00, 8'hFE, 8'h3C, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_com",  {56'h0, bus.seg_com},   64'hFF);
        chk("rst_data", {56'h0, bus.seg_data},  64'h00);
        chk("rst_fd",   {63'h0, bus.frame_done}, 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        edge_n = 0;
        run_checks = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            while (edge_n < tbl[i].at - 1) step();
            bus.load = tbl[i].ld;
            if (tbl[i].ld) bus.seg_in = tbl[i].seg;
            bus.blank_mask = tbl[i].mask;
            step();
            bus.load = 1'b0;
            chk($sformatf("com@%0d", tbl[i].at),  {56'h0, bus.seg_com},    {56'h0, tbl[i].com});
            chk($sformatf("data@%0d", tbl[i].at), {56'h0, bus.seg_data},   {56'h0, tbl[i].data});
            chk($sformatf("fd@%0d", tbl[i].at),   {63'h0, bus.frame_done}, {63'h0, tbl[i].fd});
        end

        // Asynchronous reset during digit 5 ON phase of frame 7.
        while (edge_n < 429) step();
        chk("d5_com",  {56'h0, bus.seg_com},  64'hDF);
        chk("d5_data", {56'h0, bus.seg_data}, 64'h3C);
        #2;
        rst_n = 1'b0;
        run_checks = 1'b0;
        #1;
        chk("async_com",    {56'h0, bus.seg_com},     64'hFF);
        chk("async_data",   {56'h0, bus.seg_data},    64'h00);
        chk("async_nd_com", {56'h0, bus_nd.seg_com},  64'hFF);
        repeat (2) @(posedge clk);
        #1;
        chk("held_com", {56'h0, bus.seg_com}, 64'hFF);

        @(negedge clk);
        rst_n = 1'b1;
        edge_n = 0;
        run_checks = 1'b1;
        bus_nd.load = 1'b1;
        bus_nd.seg_in = {8{8'h81}};
        step();
        bus_nd.load = 1'b0;
        chk("re_com1",    {56'h0, bus.seg_com},     64'hFF);
        chk("nd_com1",    {56'h0, bus_nd.seg_com},  64'hFE);
        chk("nd_data1",   {56'h0, bus_nd.seg_data}, 64'h00);
        while (edge_n < 3) step();
        chk("re_com3",  {56'h0, bus.seg_com},  64'hFE);
        chk("re_data3", {56'h0, bus.seg_data}, 64'h00);
        while (edge_n < 65) step();
        chk("nd_com65",  {56'h0, bus_nd.seg_com},  64'hFE);
        chk("nd_data65", {56'h0, bus_nd.seg_data}, 64'h81);
        chk("re_com65",  {56'h0, bus.seg_com},     64'hFF);
        while (edge_n < 67) step();
        chk("re_com67",  {56'h0, bus.seg_com},  64'hFE);
        chk("re_data67", {56'h0, bus.seg_data}, 64'h00);
        while (edge_n < 130) step();

        chk("onehot_errors",   onehot_err, 0);
        chk("fd_timing_errs",  fd_err,     0);
        chk("fd_pulse_count",  fd_cnt,     8);
        chk("nodead_com_errs", nd_err,     0);
        chk("pattern_a_shown", aa_seen,    0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL clear immediately when rst_n is low, independent of clk.
REQ-002 Parameter SCAN_DIV, default 10000: clock cycles per digit slot; legal range 2..65535.
REQ-003 Parameter DEAD_CYC, default 100: blanking cycles at the start of each slot; legal range 0..SCAN_DIV-1.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 seg_in  input  64  eight 8-bit segment patterns (a..g,dp, MSB=a); digit i occupies bits [8i+7:8i].
REQ-007 load  input  1  single-cycle strobe; captures seg_in into the shadow buffer.
REQ-008 blank_mask  input  8  bit i=1 keeps digit i dark for its slot.
REQ-009 seg_data  output  8  segment drive, active-high, registered.
REQ-010 seg_com  output  8  digit common select, active-low, one-hot-low or all-high, registered.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each 8-digit frame, registered.

Function
REQ-012 div_cnt SHALL count 0..SCAN_DIV-1 every cycle and wrap to 0; idx SHALL count 0..7, advancing when div_cnt wraps, 7 wrapping to 0.
REQ-013 The phase SHALL be DEAD while div_cnt < DEAD_CYC and ON otherwise; with DEAD_CYC=0 every cycle is ON.
REQ-014 Outputs SHALL be registered and lag div_cnt/idx by exactly one clock.
REQ-015 DEAD phase: seg_com=8'hFF, seg_data=8'h00.
REQ-016 ON phase, blank_mask[idx]=0: seg_com has only bit idx low; seg_data = active[idx].
REQ-017 ON phase, blank_mask[idx]=1: seg_com=8'hFF, seg_data=8'h00.
REQ-018 Whenever load=1, shadow SHALL take seg_in on that edge; multiple loads within one frame SHALL keep only the last.
REQ-019 active SHALL take shadow only on the cycle where idx=7 and div_cnt=SCAN_DIV-1 (frame boundary); the displayed frame never mixes two loads.
REQ-020 If load=1 on the frame-boundary cycle, active SHALL take seg_in directly (bypass), and shadow SHALL also take seg_in.
REQ-021 frame_done SHALL be high for exactly one cycle, on the edge following the frame-boundary cycle, and low otherwise.
REQ-022 blank_mask SHALL be sampled combinationally per cycle (not frame-buffered); a change takes effect at the next output edge.
REQ-023 At no time SHALL more than one seg_com bit be low.

Reset
REQ-024 While rst_n=0: div_cnt=0, idx=0, shadow=0, active=0, seg_com=8'hFF, seg_data=8'h00, frame_done=0.
REQ-025 Reset asserted mid-slot or mid-frame SHALL discard all buffered patterns; after release, scanning restarts at digit 0, DEAD phase.
REQ-026 The first rising edge after rst_n release SHALL process div_cnt=0, idx=0.

Verification (SCAN_DIV=8, DEAD_CYC=2 unless stated)
REQ-027 Reset release, load once with digit0=8'hFC, others 0, before first frame boundary -> frame 1 shows all zeros; frame 2 edges 3..8: seg_com=8'hFE, seg_data=8'hFC; edges 1..2: seg_com=8'hFF, seg_data=8'h00.
REQ-028 Free run 3 frames -> frame_done high exactly at edges 64, 128, 192 after release; seg_com walks FE,FD,FB,...,7F with 2 blank cycles between digits.
REQ-029 Load A mid-frame then load B mid-same-frame -> next frame displays B on all digits, never A.
REQ-030 load asserted on frame-boundary cycle with pattern C -> the immediately following frame displays C.
REQ-031 blank_mask=8'h04 -> digit 2 slot: seg_com=8'hFF, seg_data=8'h00 for all 8 cycles; other digits normal.
REQ-032 rst_n pulsed low during digit 5 ON phase -> outputs go FF/00 without a clock edge; after release, digit 0 restarts with all patterns 0; DEAD_CYC=0 run confirms no blank cycles.
